ttt_match_ctrl: RTL

Match sequencer for the tic-tac-toe board datapath. It clears the board, alternates turns between the human X player and the computer O player, and checks each move for legality before issuing it. It also detects win, draw and forfeit, keeps the match score and ends the match when one side reaches `WIN_TARGET` games. It sits between the player front-ends and the board-state register block, driving that block's `x_move`, `o_move` and reset inputs.

---
 rtl/ttt_pkg.sv | 23 ++
 rtl/ttt_match_ctrl_if.sv | 40 ++++
 rtl/ttt_move_check.sv | 10 +
 rtl/ttt_match_ctrl.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/ttt_pkg.sv
// Shared types and constants for the tic-tac-toe match sequencer.
package ttt_pkg;

    typedef enum logic [3:0] {
        StIdle,
        StClear,
        StXTurn,
        StXWait,
        StOReq,
        StOWait,
        StCheck,
        StGameOver,
        StMatchOver
    } state_e;

    localparam logic [1:0] RES_NONE = 2'b00;
    localparam logic [1:0] RES_X    = 2'b01;
    localparam logic [1:0] RES_O    = 2'b10;
    localparam logic [1:0] RES_DRAW = 2'b11;

    localparam logic [8:0] BOARD_FULL = 9'h1FF;

endpackage

// File: rtl/ttt_match_ctrl_if.sv
// Player front-end and board-block signals of the match sequencer.
interface ttt_match_ctrl_if #(
    parameter int unsigned SCORE_W = 4
);
    logic               start;
    logic               x_req;
    logic [8:0]         x_sq;
    logic               x_ack;
    logic               x_nack;
    logic               o_req;
    logic               o_valid;
    logic [8:0]         o_sq;
    logic [8:0]         board_x;
    logic [8:0]         board_o;
    logic               winner;
    logic               gs_reset;
    logic [8:0]         x_move;
    logic [8:0]         o_move;
    logic               busy;
    logic               match_done;
    logic [SCORE_W-1:0] score_x;
    logic [SCORE_W-1:0] score_o;
    logic [SCORE_W-1:0] draws;
    logic [1:0]         last_result;
    logic               err;

    // master: the sequencer itself; slave: players and board block.
    modport master (
        input  start, x_req, x_sq, o_valid, o_sq, board_x, board_o, winner,
        output x_ack, x_nack, o_req, gs_reset, x_move, o_move, busy, match_done,
               score_x, score_o, draws, last_result, err
    );

    modport slave (
        output start, x_req, x_sq, o_valid, o_sq, board_x, board_o, winner,
        input  x_ack, x_nack, o_req, gs_reset, x_move, o_move, busy, match_done,
               score_x, score_o, draws, last_result, err
    );

endinterface

// File: rtl/ttt_move_check.sv
// Move legality: square is exactly one-hot and not already occupied.
module ttt_move_check (
    input  logic [8:0] sq,
    input  logic [8:0] occupied,
    output logic       legal
);

    assign legal = (sq != 9'd0) && ((sq & (sq - 9'd1)) == 9'd0) && ((sq & occupied) == 9'd0);

endmodule

// File: rtl/ttt_match_ctrl.sv
// Match sequencer: turn order, move legality, game result and match scoring.
module ttt_match_ctrl
    import ttt_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 1000,
    parameter int unsigned WIN_TARGET     = 3,
    parameter int unsigned SCORE_W        = 4
) (
    input  logic            clk,
    input  logic            reset_n,
    ttt_match_ctrl_if.master mc
);

    localparam int unsigned TimerW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    state_e              state_q, state_d;
    logic [TimerW-1:0]   timer_q, timer_d;
    logic [8:0]          snap_q, snap_d;
    logic                mover_o_q, mover_o_d;
    logic                wait_q, wait_d;
    logic [1:0]          res_q, res_d;
    logic [SCORE_W-1:0]  score_x_q, score_x_d, score_o_q, score_o_d, draws_q, draws_d;
    logic [1:0]          last_result_q, last_result_d;
    logic                match_done_q, match_done_d;
    logic                err_q, err_d;
    logic                gs_reset_q, o_req_q, busy_q;
    logic                x_legal, o_legal, timer_exp;
    logic [8:0]          occupied, mover_board;

    assign occupied    = mc.board_x | mc.board_o;
    assign mover_board = mover_o_q ? mc.board_o : mc.board_x;
    assign timer_exp   = (timer_q == TimerW'(TIMEOUT_CYCLES - 1));

    ttt_move_check u_x_check (
        .sq       (mc.x_sq),
        .occupied (occupied),
        .legal    (x_legal)
    );

    ttt_move_check u_o_check (
        .sq       (mc.o_sq),
        .occupied (occupied),
        .legal    (o_legal)
    );

    always_comb begin
        state_d       = state_q;
        snap_d        = snap_q;
        mover_o_d     = mover_o_q;
        wait_d        = wait_q;
        res_d         = res_q;
        score_x_d     = score_x_q;
        score_o_d     = score_o_q;
        draws_d       = draws_q;
        last_result_d = last_result_q;
        match_done_d  = match_done_q;
        err_d         = err_q;
        mc.x_ack      = 1'b0;
        mc.x_nack     = 1'b0;
        mc.x_move     = 9'd0;
        mc.o_move     = 9'd0;

        case (state_q)
            StIdle: begin
                if (mc.start) state_d = StClear;
            end
            StMatchOver: begin
                if (mc.start) begin
                    state_d       = StClear;
                    score_x_d     = '0;
                    score_o_d     = '0;
                    draws_d       = '0;
                    last_result_d = RES_NONE;
                    match_done_d  = 1'b0;
                end
            end
            StClear: state_d = StXTurn;
            StXTurn: begin
                // A legal move in the expiry cycle beats the timeout.
                if (mc.x_req && x_legal) begin
                    mc.x_ack  = 1'b1;
                    mc.x_move = mc.x_sq;
                    snap_d    = mc.board_x | mc.x_sq;
                    mover_o_d = 1'b0;
                    wait_d    = 1'b0;
                    state_d   = StXWait;
                end else begin
                    mc.x_nack = mc.x_req;
                    if (timer_exp) begin
                        res_d   = RES_O;
                        state_d = StGameOver;
                    end
                end
            end
            StXWait: begin
                wait_d = 1'b1;
                if (wait_q) state_d = StCheck;
            end
            StOReq: begin
                if (mc.o_valid) begin
                    if (o_legal) begin
                        mc.o_move = mc.o_sq;
                        snap_d    = mc.board_o | mc.o_sq;
                        mover_o_d = 1'b1;
                        state_d   = StOWait;
                    end else begin
                        res_d   = RES_X;
                        state_d = StGameOver;
                    end
                end else if (timer_exp) begin
                    res_d   = RES_X;
                    state_d = StGameOver;
                end
            end
            StOWait: state_d = StCheck;
            StCheck: begin
                if (mover_board != snap_q) err_d = 1'b1;
                if (mc.winner) begin
                    res_d   = mover_o_q ? RES_O : RES_X;
                    state_d = StGameOver;
                end else if (occupied == BOARD_FULL) begin
                    res_d   = RES_DRAW;
                    state_d = StGameOver;
                end else begin
                    state_d = mover_o_q ? StXTurn : StOReq;
                end
            end
            StGameOver: begin
                last_result_d = res_q;
                case (res_q)
                    RES_X:    score_x_d = score_x_q + 1'b1;
                    RES_O:    score_o_d = score_o_q + 1'b1;
                    RES_DRAW: draws_d   = draws_q + 1'b1;
                    default:  ;
                endcase
                if ((score_x_d == SCORE_W'(WIN_TARGET)) || (score_o_d == SCORE_W'(WIN_TARGET))) begin
                    match_done_d = 1'b1;
                    state_d      = StMatchOver;
                end else begin
                    state_d = StClear;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Timer restarts whenever a turn state is freshly entered.
    assign timer_d = ((state_d == state_q) && ((state_q == StXTurn) || (state_q == StOReq))) ?
                     timer_q + 1'b1 : '0;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= StIdle;
            timer_q       <= '0;
            snap_q        <= 9'd0;
            mover_o_q     <= 1'b0;
            wait_q        <= 1'b0;
            res_q         <= RES_NONE;
            score_x_q     <= '0;
            score_o_q     <= '0;
            draws_q       <= '0;
            last_result_q <= RES_NONE;
            match_done_q  <= 1'b0;
            err_q         <= 1'b0;
            gs_reset_q    <= 1'b0;
            o_req_q       <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            timer_q       <= timer_d;
            snap_q        <= snap_d;
            mover_o_q     <= mover_o_d;
            wait_q        <= wait_d;
            res_q         <= res_d;
            score_x_q     <= score_x_d;
            score_o_q     <= score_o_d;
            draws_q       <= draws_d;
            last_result_q <= last_result_d;
            match_done_q  <= match_done_d;
            err_q         <= err_d;
            gs_reset_q    <= (state_d == StClear);
            o_req_q       <= (state_d == StOReq);
            busy_q        <= (state_d != StIdle) && (state_d != StMatchOver);
        end
    end

    assign mc.gs_reset    = gs_reset_q;
    assign mc.o_req       = o_req_q;
    assign mc.busy        = busy_q;
    assign mc.match_done  = match_done_q;
    assign mc.score_x     = score_x_q;
    assign mc.score_o     = score_o_q;
    assign mc.draws       = draws_q;
    assign mc.last_result = last_result_q;
    assign mc.err         = err_q;

endmodule
